// File: rtl/program_loader_if.sv
// Program loader bus: byte-stream input, instruction-memory write port and
// core control/status. The loader is the master; the environment is the slave.
interface program_loader_if;
    logic        load_start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        error;

    modport master (
        input  load_start, rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error
    );

    modport slave (
        output load_start, rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error
    );
endinterface

// File: rtl/program_loader.sv
// Program loader: receives a length-prefixed little-endian byte stream, writes
// the assembled 32-bit words into instruction memory and holds the core in
// reset until the whole program has been written.
module program_loader #(
    parameter int unsigned IMEM_WORDS = 64,
    parameter logic [63:0] BASE_ADDR  = 64'd0
) (
    input logic              clk,
    input logic              reset,
    program_loader_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StWrite,
        StDone,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;

    logic        accept;
    logic [15:0] hdr_len;
    logic [15:0] word_cnt_inc;

    assign accept       = bus.rx_valid & bus.rx_ready;
    assign hdr_len      = {bus.rx_data, len_q[7:0]};
    assign word_cnt_inc = word_cnt_q + 16'd1;

    // State and datapath registers; reset wins over any same-cycle traffic.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
        end
    end

    // Next-state logic: header capture, word assembly and write sequencing.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (bus.load_start) begin
                    state_d = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d   = {8'h00, bus.rx_data};
                    state_d = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d = hdr_len;
                    if ((hdr_len == 16'd0) || (32'(hdr_len) > IMEM_WORDS)) begin
                        state_d = StErr;
                    end else begin
                        state_d    = StData;
                        word_cnt_d = '0;
                        byte_cnt_d = '0;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = bus.rx_data;
                    byte_cnt_d                        = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                // Address/data were presented this cycle using the old count.
                word_cnt_d = word_cnt_inc;
                byte_cnt_d = '0;
                state_d    = (word_cnt_inc == len_q) ? StDone : StData;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.rx_ready   = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
    assign bus.imem_we    = (state_q == StWrite);
    // Registered sources only, so both stay stable between clock edges.
    assign bus.imem_addr  = BASE_ADDR + {46'd0, word_cnt_q, 2'b00};
    assign bus.imem_wdata = word_q;
    assign bus.core_reset = (state_q != StDone);
    assign bus.done       = (state_q == StDone);
    assign bus.error      = (state_q == StErr);

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: drives length-prefixed byte streams and compares
// every instruction-memory write and the final status against a stream model.
module tb_program_loader;

    localparam int unsigned IMEM_WORDS = 64;
    localparam logic [63:0] BASE_ADDR  = 64'd0;

    logic clk = 1'b0;
    logic reset;

    program_loader_if bus ();

    program_loader #(
        .IMEM_WORDS(IMEM_WORDS),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Free-running edge counter and write/done monitor.
    int          cyc = 0;
    logic [95:0] got_q[$];
    int          done_rise_cyc = -1;
    logic        done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) got_q.push_back({bus.imem_addr, bus.imem_wdata});
        if (bus.done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
        done_prev = bus.done;
    end

    // Stimulus and reference state.
    logic [7:0]  stim[$];
    logic [95:0] exp_q[$];
    bit          exp_err;
    int          wr_base;
    int          start_cyc;
    logic        err_at_start;

    // Expected writes derived directly from the stream format.
    task automatic build_model();
        int n;
        logic [31:0] w;
        exp_q.delete();
        n = int'(stim[0]) + 256 * int'(stim[1]);
        exp_err = (n == 0) || (n > int'(IMEM_WORDS));
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                w = {stim[2+4*i+3], stim[2+4*i+2], stim[2+4*i+1], stim[2+4*i]};
                exp_q.push_back({BASE_ADDR + 64'(4 * i), w});
            end
        end
    endtask

    task automatic make_stream(input int n, input bit hdr_only);
        logic [15:0] len;
        len = 16'(n);
        stim.delete();
        stim.push_back(len[7:0]);
        stim.push_back(len[15:8]);
        if (!hdr_only) begin
            for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom_range(255, 0)));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_ls);
        logic acc;
        for (int g = 0; g < gap; g++) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom_range(255, 0));
            tick();
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        if (pulse_ls) bus.load_start = 1'b1;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            acc = bus.rx_ready;
            tick();
            bus.load_start = 1'b0;
            if (acc === 1'b1) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: byte %h got rx_ready=0 for 40 cycles, required 1", b);
    endtask

    task automatic run_load(input int stall, input bit fixed_gap, input int pulse_at);
        int gap;
        build_model();
        wr_base = got_q.size();
        pulse_load();
        start_cyc    = cyc;
        err_at_start = bus.error;
        foreach (stim[i]) begin
            gap = fixed_gap ? stall : $urandom_range(stall, 0);
            send_byte(stim[i], gap, i == pulse_at);
        end
        bus.rx_valid = 1'b0;
        for (int g = 0; g < 20; g++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.error === 1'b1) break;
        end
        tick();
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.load_start = 1'b1;
        bus.rx_valid   = 1'b1;
        bus.rx_data    = 8'h5A;
        tick();
        tick();
        bus.load_start = 1'b0;
        bus.rx_valid   = 1'b0;
        vectors++;
        if ({bus.rx_ready, bus.imem_we, bus.core_reset, bus.done, bus.error} !== 5'b00100) begin
            miscompares++;
            $display("FAIL reset_ctrl: got rdy/we/crst/done/err=%b, required 00100",
                     {bus.rx_ready, bus.imem_we, bus.core_reset, bus.done, bus.error});
        end
        vectors++;
        if (bus.imem_addr !== BASE_ADDR || bus.imem_wdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_bus: got addr=%h wdata=%h, required %h/0",
                     bus.imem_addr, bus.imem_wdata, BASE_ADDR);
        end
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if (bus.rx_ready !== 1'b0 || bus.core_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_idle: got rx_ready=%b core_reset=%b, required 0/1",
                     bus.rx_ready, bus.core_reset);
        end
    endtask

    task automatic test_basic_stream();
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        run_load(0, 1'b1, -1);
        vectors++;
        if (got_q.size() - wr_base !== 2) begin
            miscompares++;
            $display("FAIL basic_count: got %0d writes, required 2", got_q.size() - wr_base);
        end else begin
            vectors++;
            if (got_q[wr_base] !== {64'd0, 32'h00A00513}) begin
                miscompares++;
                $display("FAIL basic_w0: got %h, required addr 0 data 00A00513", got_q[wr_base]);
            end
            vectors++;
            if (got_q[wr_base+1] !== {64'd4, 32'h00100593}) begin
                miscompares++;
                $display("FAIL basic_w1: got %h, required addr 4 data 00100593",
                         got_q[wr_base+1]);
            end
        end
        vectors++;
        if (done_rise_cyc - start_cyc !== 12) begin
            miscompares++;
            $display("FAIL basic_latency: got done %0d cycles after start, required 12",
                     done_rise_cyc - start_cyc);
        end
        vectors++;
        if (bus.done !== 1'b1 || bus.core_reset !== 1'b0 || bus.error !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_status: got done=%b core_reset=%b error=%b, required 1/0/0",
                     bus.done, bus.core_reset, bus.error);
        end
    endtask

    task automatic test_zero_length();
        make_stream(0, 1'b1);
        run_load(0, 1'b1, -1);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hEE;
        for (int i = 0; i < 5; i++) tick();
        bus.rx_valid = 1'b0;
        vectors++;
        if ({bus.error, bus.core_reset, bus.rx_ready, bus.done} !== 4'b1100) begin
            miscompares++;
            $display("FAIL zero_status: got err/crst/rdy/done=%b, required 1100",
                     {bus.error, bus.core_reset, bus.rx_ready, bus.done});
        end
        vectors++;
        if (got_q.size() !== wr_base) begin
            miscompares++;
            $display("FAIL zero_writes: got %0d writes, required 0", got_q.size() - wr_base);
        end
    endtask

    task automatic test_overlength_recover();
        make_stream(65, 1'b1);
        run_load(0, 1'b1, -1);
        vectors++;
        if (bus.error !== 1'b1 || got_q.size() !== wr_base) begin
            miscompares++;
            $display("FAIL over_err: got error=%b writes=%0d, required 1/0",
                     bus.error, got_q.size() - wr_base);
        end
        make_stream(1, 1'b0);
        run_load(0, 1'b1, -1);
        vectors++;
        if (err_at_start !== 1'b0) begin
            miscompares++;
            $display("FAIL over_clear: got error=%b after load_start, required 0", err_at_start);
        end
        vectors++;
        if (got_q.size() - wr_base !== 1 || got_q[wr_base] !== exp_q[0]) begin
            miscompares++;
            $display("FAIL over_word: got %0d writes first=%h, required 1 of %h",
                     got_q.size() - wr_base, got_q[wr_base], exp_q[0]);
        end
        vectors++;
        if (bus.done !== 1'b1 || bus.error !== 1'b0) begin
            miscompares++;
            $display("FAIL over_done: got done=%b error=%b, required 1/0", bus.done, bus.error);
        end
    endtask

    task automatic test_stalled_word();
        make_stream(1, 1'b0);
        run_load(2, 1'b1, -1);
        vectors++;
        if (got_q.size() - wr_base !== 1) begin
            miscompares++;
            $display("FAIL stall_count: got %0d writes, required 1", got_q.size() - wr_base);
        end else begin
            vectors++;
            if (got_q[wr_base] !== exp_q[0]) begin
                miscompares++;
                $display("FAIL stall_word: got %h, required %h", got_q[wr_base], exp_q[0]);
            end
        end
        vectors++;
        if (bus.done !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_done: got done=%b, required 1", bus.done);
        end
    endtask

    task automatic test_reset_mid_load();
        int base;
        make_stream(3, 1'b0);
        pulse_load();
        for (int i = 0; i < 4; i++) send_byte(stim[i], 0, 1'b0);
        base           = got_q.size();
        reset          = 1'b1;
        bus.load_start = 1'b1;
        bus.rx_data    = stim[4];
        tick();
        reset          = 1'b0;
        bus.load_start = 1'b0;
        vectors++;
        if ({bus.rx_ready, bus.core_reset, bus.done, bus.error} !== 4'b0100) begin
            miscompares++;
            $display("FAIL midrst_status: got rdy/crst/done/err=%b, required 0100",
                     {bus.rx_ready, bus.core_reset, bus.done, bus.error});
        end
        vectors++;
        if (bus.imem_addr !== BASE_ADDR || bus.imem_wdata !== 32'd0) begin
            miscompares++;
            $display("FAIL midrst_bus: got addr=%h wdata=%h, required %h/0",
                     bus.imem_addr, bus.imem_wdata, BASE_ADDR);
        end
        for (int i = 0; i < 10; i++) tick();
        bus.rx_valid = 1'b0;
        vectors++;
        if (got_q.size() !== base) begin
            miscompares++;
            $display("FAIL midrst_writes: got %0d writes after reset, required 0",
                     got_q.size() - base);
        end
    endtask

    task automatic test_load_start_ignored();
        for (int p = 5; p <= 6; p++) begin
            make_stream(3, 1'b0);
            run_load(0, 1'b1, p);
            vectors++;
            if (got_q.size() - wr_base !== exp_q.size()) begin
                miscompares++;
                $display("FAIL ignore_count: pulse@%0d got %0d writes, required %0d",
                         p, got_q.size() - wr_base, exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    vectors++;
                    if (got_q[wr_base+i] !== exp_q[i]) begin
                        miscompares++;
                        $display("FAIL ignore_word%0d: got %h, required %h",
                                 i, got_q[wr_base+i], exp_q[i]);
                    end
                end
            end
            vectors++;
            if (bus.done !== 1'b1) begin
                miscompares++;
                $display("FAIL ignore_done: pulse@%0d got done=%b, required 1", p, bus.done);
            end
        end
    endtask

    task automatic test_full_capacity();
        int nw;
        make_stream(int'(IMEM_WORDS), 1'b0);
        run_load(0, 1'b1, -1);
        nw = got_q.size() - wr_base;
        vectors++;
        if (nw !== int'(IMEM_WORDS)) begin
            miscompares++;
            $display("FAIL full_count: got %0d writes, required %0d", nw, IMEM_WORDS);
        end else begin
            vectors++;
            if (got_q[wr_base+nw-1][95:32] !== BASE_ADDR + 64'(4 * (IMEM_WORDS - 1))) begin
                miscompares++;
                $display("FAIL full_last_addr: got %h, required %h", got_q[wr_base+nw-1][95:32],
                         BASE_ADDR + 64'(4 * (IMEM_WORDS - 1)));
            end
            foreach (exp_q[i]) begin
                vectors++;
                if (got_q[wr_base+i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL full_word%0d: got %h, required %h",
                             i, got_q[wr_base+i], exp_q[i]);
                end
            end
        end
        vectors++;
        if (done_rise_cyc - start_cyc !== 2 + 5 * int'(IMEM_WORDS) || bus.done !== 1'b1) begin
            miscompares++;
            $display("FAIL full_latency: got %0d cycles done=%b, required %0d and 1",
                     done_rise_cyc - start_cyc, bus.done, 2 + 5 * int'(IMEM_WORDS));
        end
    endtask

    task automatic test_random_loads();
        int n;
        int r;
        for (int it = 0; it < 8; it++) begin
            r = $urandom_range(9, 0);
            if (r == 0) n = 0;
            else if (r == 9) n = $urandom_range(300, int'(IMEM_WORDS) + 1);
            else n = $urandom_range(8, 1);
            make_stream(n, (r == 0) || (r == 9));
            run_load($urandom_range(3, 0), 1'b0, -1);
            vectors++;
            if (got_q.size() - wr_base !== exp_q.size()) begin
                miscompares++;
                $display("FAIL rand%0d_count: n=%0d got %0d writes, required %0d",
                         it, n, got_q.size() - wr_base, exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    vectors++;
                    if (got_q[wr_base+i] !== exp_q[i]) begin
                        miscompares++;
                        $display("FAIL rand%0d_word%0d: got %h, required %h",
                                 it, i, got_q[wr_base+i], exp_q[i]);
                    end
                end
            end
            vectors++;
            if (bus.error !== exp_err || bus.done !== !exp_err) begin
                miscompares++;
                $display("FAIL rand%0d_status: n=%0d got error=%b done=%b, required %b/%b",
                         it, n, bus.error, bus.done, exp_err, !exp_err);
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.load_start = 1'b0;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        test_reset();
        test_basic_stream();
        test_zero_length();
        test_overlength_recover();
        test_stalled_word();
        test_reset_mid_load();
        test_load_start_ignored();
        test_full_capacity();
        test_random_loads();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
